// File: rtl/frame_border_pkg.sv
// Shared types for the frame border generator: border mode, FSM states, emit segments
// and the byte-rounded AXI-Stream data width helper.
package frame_border_pkg;

  typedef enum logic {
    BORDER_REPLICATE = 1'b0,
    BORDER_CONSTANT  = 1'b1
  } border_mode_t;

  typedef enum logic [2:0] {
    IDLE_S, CAPTURE_S, TOP_S, LEFT_S, PASS_S, RIGHT_S, BOT_S
  } fbg_state_t;

  // Position inside a line replayed from the line RAM (TOP_S / BOT_S)
  typedef enum logic [1:0] {
    SEG_LEFT, SEG_BODY, SEG_RIGHT
  } seg_t;

  function automatic int tdata_width(input int channels, input int px_width);
    return ((channels * px_width + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle used for the video ports (tuser = SOF, tlast = EOL).
interface axi4_stream_if #(parameter int DATA_W = 8);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/border_line_ram.sv
// Simple dual-port line RAM, one write and one read port, 1-cycle read latency.
// Read data is held until the next read so a stalled output stage keeps its value.
module border_line_ram #(
  parameter  int DEPTH = 1920,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/frame_border_gen.sv
// Extends each video frame with TOP/BOTTOM/LEFT/RIGHT border pixels (replicate or constant).
// Optional FRAME_BORDER_GEN_STATS_EN adds output frame and line-error counters.
module frame_border_gen
  import frame_border_pkg::*;
#(
  parameter  int TOP         = 1,
  parameter  int BOTTOM      = 1,
  parameter  int LEFT        = 1,
  parameter  int RIGHT       = 1,
  parameter  int FRAME_RES_X = 1920,
  parameter  int FRAME_RES_Y = 1080,
  parameter  int PX_WIDTH    = 10,
  parameter  int CHANNELS    = 1,
  localparam int TW          = tdata_width(CHANNELS, PX_WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o,
  input  logic          mode_i,
  input  logic [TW-1:0] const_px_i,
  output logic          line_err_o
`ifdef FRAME_BORDER_GEN_STATS_EN
  ,
  output logic [31:0]   frames_cnt_o,
  output logic [15:0]   err_cnt_o
`endif
);
  localparam int          AW     = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam logic [15:0] LAST_X = 16'(FRAME_RES_X - 1);
  localparam logic [15:0] LAST_Y = 16'(FRAME_RES_Y - 1);
  localparam seg_t        SEG0   = (LEFT > 0) ? SEG_LEFT : SEG_BODY;

  fbg_state_t   state_q, nxt_line_state;
  seg_t         seg_q;
  border_mode_t mode_q;
  logic [15:0]  x_q, y_q, b_q, rep_q, nxt_y;
  logic [TW-1:0] const_q, first_q, last_q, left_val, right_val, iss_data, p_data, ram_rdata;
  logic pad_q, drop_q, sof_q, started_q, line_err_q;
  logic p_valid_q, p_ram_q, p_user_q, p_last_q;
  logic o_valid_q, o_user_q, o_last_q;
  logic [TW-1:0] p_data_q, o_data_q;
  logic o_free, adv, in_rdy, accept, issue, iss_ram, iss_last, const_line;
  logic px_acc, px_pad, px_any, line_done, long_line, short_line, drop_end, in_line_end;

  assign o_free     = !o_valid_q || video_o.tready;
  assign adv        = !p_valid_q || o_free;
  assign left_val   = (mode_q == BORDER_CONSTANT) ? const_q : first_q;
  assign right_val  = (mode_q == BORDER_CONSTANT) ? const_q : last_q;
  // In constant mode only the final TOP repetition (the real line 0) comes from RAM
  assign const_line = (mode_q == BORDER_CONSTANT) && ((state_q == BOT_S) || (rep_q != 16'(TOP)));

  always_comb begin
    in_rdy   = 1'b0;
    issue    = 1'b0;
    iss_ram  = 1'b0;
    iss_data = const_q;
    iss_last = 1'b0;
    px_acc   = 1'b0;
    px_pad   = 1'b0;
    case (state_q)
      IDLE_S: begin
        in_rdy = started_q;
        px_acc = started_q && video_i.tvalid && video_i.tuser;
      end
      CAPTURE_S: begin
        in_rdy = !pad_q;
        px_acc = video_i.tvalid && !pad_q && !drop_q;
        px_pad = pad_q;
      end
      TOP_S, BOT_S: begin
        issue = adv;
        case (seg_q)
          SEG_LEFT:  iss_data = left_val;
          SEG_RIGHT: begin
            iss_data = right_val;
            iss_last = (b_q == 16'(RIGHT - 1));
          end
          default: begin
            iss_ram  = !const_line;
            iss_last = (RIGHT == 0) && (x_q == LAST_X);
          end
        endcase
      end
      LEFT_S: begin
        issue    = adv && video_i.tvalid;
        iss_data = (mode_q == BORDER_CONSTANT) ? const_q : video_i.tdata;
      end
      PASS_S: begin
        iss_last = (RIGHT == 0) && (x_q == LAST_X);
        if (drop_q) begin
          in_rdy = 1'b1;
        end else if (pad_q) begin
          issue    = adv;
          px_pad   = adv;
          iss_data = last_q;
        end else begin
          // video_o.tready high implies adv, so a forwarded pixel always has room
          in_rdy   = video_o.tready;
          px_acc   = video_i.tvalid && video_o.tready;
          issue    = px_acc;
          iss_data = video_i.tdata;
        end
      end
      RIGHT_S: begin
        issue    = adv;
        iss_data = right_val;
        iss_last = (b_q == 16'(RIGHT - 1));
      end
      default: ;
    endcase
  end

  assign accept      = video_i.tvalid && in_rdy;
  assign px_any      = px_acc || px_pad;
  assign line_done   = px_any && (x_q == LAST_X);
  assign long_line   = line_done && px_acc && !video_i.tlast;
  assign short_line  = px_acc && video_i.tlast && !line_done;
  assign drop_end    = drop_q && accept && video_i.tlast;
  assign in_line_end = (line_done && !long_line) || drop_end;

  always_comb begin
    if (y_q == LAST_Y) begin
      nxt_line_state = (BOTTOM > 0) ? BOT_S : IDLE_S;
      nxt_y          = y_q;
    end else begin
      nxt_line_state = (LEFT > 0) ? LEFT_S : PASS_S;
      nxt_y          = y_q + 16'd1;
    end
  end

  border_line_ram #(.DEPTH(FRAME_RES_X), .WIDTH(TW)) u_ram (
    .clk_i  (clk_i),
    .we_i   (px_any),
    .waddr_i(x_q[AW-1:0]),
    .wdata_i(px_acc ? video_i.tdata : last_q),
    .re_i   (issue && iss_ram),
    .raddr_i(x_q[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE_S;    seg_q <= SEG_LEFT;   mode_q <= BORDER_REPLICATE;
      x_q <= '0;  y_q <= '0;  b_q <= '0;  rep_q <= '0;
      const_q <= '0;  first_q <= '0;  last_q <= '0;
      pad_q <= 1'b0;  drop_q <= 1'b0;  sof_q <= 1'b0;  started_q <= 1'b0;  line_err_q <= 1'b0;
    end else begin
      started_q  <= 1'b1;
      line_err_q <= short_line || long_line;
      if (issue) sof_q <= 1'b0;
      if (px_acc) begin
        last_q <= video_i.tdata;
        if (x_q == '0) first_q <= video_i.tdata;
      end
      if (px_any) x_q <= line_done ? '0 : x_q + 16'd1;
      if (short_line) pad_q <= 1'b1;
      if (line_done) pad_q <= 1'b0;
      if (long_line) drop_q <= 1'b1;
      if (drop_end) drop_q <= 1'b0;
      case (state_q)
        IDLE_S: begin
          mode_q  <= border_mode_t'(mode_i);
          const_q <= const_px_i;
          if (px_acc) begin
            sof_q   <= 1'b1;
            y_q     <= '0;  b_q <= '0;  rep_q <= '0;  seg_q <= SEG0;
            state_q <= in_line_end ? TOP_S : CAPTURE_S;
          end
        end
        CAPTURE_S: if (in_line_end) state_q <= TOP_S;
        TOP_S, BOT_S: if (issue) begin
          case (seg_q)
            SEG_LEFT: begin
              if (b_q == 16'(LEFT - 1)) begin b_q <= '0; seg_q <= SEG_BODY; end
              else b_q <= b_q + 16'd1;
            end
            SEG_RIGHT: b_q <= iss_last ? '0 : b_q + 16'd1;
            default: begin
              if (x_q == LAST_X) begin
                x_q <= '0;
                if (RIGHT > 0) seg_q <= SEG_RIGHT;
              end else x_q <= x_q + 16'd1;
            end
          endcase
          if (iss_last) begin
            seg_q <= SEG0;
            if (state_q == TOP_S && rep_q == 16'(TOP)) begin
              rep_q <= '0;  y_q <= nxt_y;  state_q <= nxt_line_state;
            end else if (state_q == BOT_S && rep_q == 16'(BOTTOM - 1)) begin
              rep_q <= '0;  state_q <= IDLE_S;
            end else rep_q <= rep_q + 16'd1;
          end
        end
        LEFT_S: if (issue) begin
          if (b_q == 16'(LEFT - 1)) begin b_q <= '0; state_q <= PASS_S; end
          else b_q <= b_q + 16'd1;
        end
        PASS_S: if (in_line_end) begin
          if (RIGHT > 0) state_q <= RIGHT_S;
          else begin y_q <= nxt_y; state_q <= nxt_line_state; seg_q <= SEG0; end
        end
        RIGHT_S: if (issue) begin
          if (iss_last) begin
            b_q <= '0;  y_q <= nxt_y;  state_q <= nxt_line_state;  seg_q <= SEG0;
          end else b_q <= b_q + 16'd1;
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  // Two-stage output: p_* waits for RAM read data, o_* drives video_o
  assign p_data = p_ram_q ? ram_rdata : p_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_valid_q <= 1'b0; p_ram_q <= 1'b0; p_user_q <= 1'b0; p_last_q <= 1'b0; p_data_q <= '0;
      o_valid_q <= 1'b0; o_user_q <= 1'b0; o_last_q <= 1'b0; o_data_q <= '0;
    end else begin
      if (o_free) begin
        o_valid_q <= p_valid_q;
        o_data_q  <= p_data;
        o_user_q  <= p_valid_q && p_user_q;
        o_last_q  <= p_valid_q && p_last_q;
      end
      if (adv) begin
        p_valid_q <= issue;
        p_ram_q   <= issue && iss_ram;
        p_data_q  <= iss_data;
        p_user_q  <= issue && sof_q;
        p_last_q  <= issue && iss_last;
      end
    end
  end

  assign video_i.tready = in_rdy;
  assign video_o.tvalid = o_valid_q;
  assign video_o.tdata  = o_data_q;
  assign video_o.tuser  = o_user_q;
  assign video_o.tlast  = o_last_q;
  assign line_err_o     = line_err_q;

`ifdef FRAME_BORDER_GEN_STATS_EN
  logic busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;  frames_cnt_o <= '0;  err_cnt_o <= '0;
    end else begin
      busy_q <= (state_q != IDLE_S);
      if (busy_q && state_q == IDLE_S) frames_cnt_o <= frames_cnt_o + 32'd1;
      if (line_err_q && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_frame_border_gen.sv
// Scoreboard bench for frame_border_gen: a 4x3 frame with 1-pixel borders and a
// 4x3 frame with no borders; expected beats are queued by the stimulus, popped by monitors.
module tb_frame_border_gen;
  typedef struct packed { logic [7:0] d; logic u; logic l; } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] cpx = 8'h00;
  logic       err_a, err_z;
  bit         rnd_rdy = 1'b0;
  bit         ignore_a = 1'b0;
  int         checks = 0, failures = 0;
  int         err_cnt_a = 0, err_cnt_z = 0;
  beat_t      exp_a[$], exp_z[$];

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_W(8)) in_a ();
  axi4_stream_if #(.DATA_W(8)) out_a ();
  axi4_stream_if #(.DATA_W(8)) in_z ();
  axi4_stream_if #(.DATA_W(8)) out_z ();

  frame_border_gen #(.TOP(1), .BOTTOM(1), .LEFT(1), .RIGHT(1), .FRAME_RES_X(4), .FRAME_RES_Y(3),
                     .PX_WIDTH(8), .CHANNELS(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .video_i(in_a), .video_o(out_a),
    .mode_i(mode), .const_px_i(cpx), .line_err_o(err_a));

  frame_border_gen #(.TOP(0), .BOTTOM(0), .LEFT(0), .RIGHT(0), .FRAME_RES_X(4), .FRAME_RES_Y(3),
                     .PX_WIDTH(8), .CHANNELS(1)) dut_z (
    .clk_i(clk), .rst_i(rst), .video_i(in_z), .video_o(out_z),
    .mode_i(mode), .const_px_i(cpx), .line_err_o(err_z));

  always @(posedge clk) begin
    #1;
    out_a.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    out_z.tready = 1'b1;
  end

  beat_t held_a;
  bit    stalled_a = 1'b0;

  always @(negedge clk) begin
    beat_t got, e;
    if (rst) stalled_a = 1'b0;
    else begin
      if (err_a) err_cnt_a++;
      got = {out_a.tdata, out_a.tuser, out_a.tlast};
      if (stalled_a && !ignore_a) begin
        checks++;
        if (!out_a.tvalid || got != held_a) begin
          failures++;
          $display("FAIL stall_hold_a got v=%0b d=%0d u=%0b l=%0b required d=%0d u=%0b l=%0b",
                   out_a.tvalid, got.d, got.u, got.l, held_a.d, held_a.u, held_a.l);
        end
      end
      stalled_a = out_a.tvalid && !out_a.tready;
      held_a    = got;
      if (out_a.tvalid && out_a.tready && !ignore_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          failures++;
          $display("FAIL extra_beat_a got d=%0d u=%0b l=%0b required none", got.d, got.u, got.l);
        end else begin
          e = exp_a.pop_front();
          if (got != e) begin
            failures++;
            $display("FAIL beat_a got d=%0d u=%0b l=%0b required d=%0d u=%0b l=%0b",
                     got.d, got.u, got.l, e.d, e.u, e.l);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t got, e;
    if (!rst) begin
      if (err_z) err_cnt_z++;
      got = {out_z.tdata, out_z.tuser, out_z.tlast};
      if (out_z.tvalid && out_z.tready) begin
        checks++;
        if (exp_z.size() == 0) begin
          failures++;
          $display("FAIL extra_beat_z got d=%0d u=%0b l=%0b required none", got.d, got.u, got.l);
        end else begin
          e = exp_z.pop_front();
          if (got != e) begin
            failures++;
            $display("FAIL beat_z got d=%0d u=%0b l=%0b required d=%0d u=%0b l=%0b",
                     got.d, got.u, got.l, e.d, e.u, e.l);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic u, input logic l);
    int n = 0;
    in_a.tdata = d; in_a.tuser = u; in_a.tlast = l; in_a.tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_a.tready && n < 2000);
    if (!in_a.tready) check("timeout_in_a", 0, 1);
    @(posedge clk); #1;
    in_a.tvalid = 1'b0;
  endtask

  task automatic send_z(input logic [7:0] d, input logic u, input logic l);
    int n = 0;
    in_z.tdata = d; in_z.tuser = u; in_z.tlast = l; in_z.tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_z.tready && n < 2000);
    if (!in_z.tready) check("timeout_in_z", 0, 1);
    @(posedge clk); #1;
    in_z.tvalid = 1'b0;
  endtask

  // Input frame 1..12; short_l1 truncates line 1 to 5 6 7
  task automatic send_frame_a(input bit short_l1);
    for (int y = 0; y < 3; y++) begin
      int len = (short_l1 && y == 1) ? 3 : 4;
      for (int x = 0; x < len; x++)
        send_a(8'(y * 4 + x + 1), (x == 0 && y == 0), (x == len - 1));
    end
  endtask

  task automatic push_rows_a(input int tab [30]);
    for (int i = 0; i < 30; i++) exp_a.push_back({8'(tab[i]), (i == 0), (i % 6 == 5)});
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_a.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("drain_a_left", exp_a.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drain_z();
    int n = 0;
    while (exp_z.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("drain_z_left", exp_z.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  int rep_tab [30] = '{1, 1, 2, 3, 4, 4,   1, 1, 2, 3, 4, 4,   5, 5, 6, 7, 8, 8,
                       9, 9, 10, 11, 12, 12,   9, 9, 10, 11, 12, 12};
  int con_tab [30] = '{170, 170, 170, 170, 170, 170,   170, 1, 2, 3, 4, 170,
                       170, 5, 6, 7, 8, 170,   170, 9, 10, 11, 12, 170,
                       170, 170, 170, 170, 170, 170};
  int sht_tab [30] = '{1, 1, 2, 3, 4, 4,   1, 1, 2, 3, 4, 4,   5, 5, 6, 7, 7, 7,
                       9, 9, 10, 11, 12, 12,   9, 9, 10, 11, 12, 12};

  initial begin
    in_a.tvalid = 1'b0; in_a.tdata = '0; in_a.tuser = 1'b0; in_a.tlast = 1'b0;
    in_z.tvalid = 1'b0; in_z.tdata = '0; in_z.tuser = 1'b0; in_z.tlast = 1'b0;
    out_a.tready = 1'b1; out_z.tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", out_a.tvalid, 0);
    check("rst_tuser", out_a.tuser, 0);
    check("rst_tlast", out_a.tlast, 0);
    check("rst_in_tready", in_a.tready, 0);
    check("rst_line_err", err_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Replicate borders
    mode = 1'b0;
    push_rows_a(rep_tab);
    send_frame_a(1'b0);
    drain_a();
    check("err_after_replicate", err_cnt_a, 0);

    // Constant borders
    mode = 1'b1; cpx = 8'hAA;
    push_rows_a(con_tab);
    send_frame_a(1'b0);
    drain_a();

    // Random output backpressure
    mode = 1'b0;
    rnd_rdy = 1'b1;
    push_rows_a(rep_tab);
    send_frame_a(1'b0);
    drain_a();
    rnd_rdy = 1'b0;
    check("err_after_random", err_cnt_a, 0);

    // Short middle line is padded with its last pixel
    push_rows_a(sht_tab);
    send_frame_a(1'b1);
    drain_a();
    check("err_short_line", err_cnt_a, 1);

    // Reset while forwarding line 1
    ignore_a = 1'b1;
    for (int x = 0; x < 4; x++) send_a(8'(x + 1), (x == 0), (x == 3));
    send_a(8'd5, 1'b0, 1'b0);
    send_a(8'd6, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tvalid", out_a.tvalid, 0);
    check("midrst_in_tready", in_a.tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    ignore_a = 1'b0;
    push_rows_a(rep_tab);
    send_frame_a(1'b0);
    drain_a();

    // No borders: output equals input; line 1 carries one extra pixel to be dropped
    for (int i = 0; i < 12; i++) exp_z.push_back({8'(i + 1), (i == 0), (i % 4 == 3)});
    for (int x = 0; x < 4; x++) send_z(8'(x + 1), (x == 0), (x == 3));
    for (int x = 0; x < 4; x++) send_z(8'(x + 5), 1'b0, 1'b0);
    send_z(8'd99, 1'b0, 1'b1);
    for (int x = 0; x < 4; x++) send_z(8'(x + 9), 1'b0, (x == 3));
    drain_z();
    check("err_long_line_z", err_cnt_z, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
